// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the ID/EX stage register: load-use
// stall, branch flush, operand forwarding selects and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [2:0]             id_rs,
    input  logic [2:0]             id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_load,
    input  logic                   branch_taken,
    output logic                   ifid_hold,
    output logic                   idex_enable,
    output logic                   idex_clear,
    output logic [1:0]             fwd_rs_sel,
    output logic [1:0]             fwd_rd_sel,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] rd;
        logic       reg_write;
        logic       load;
    } trk_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam trk_t       TRK_NONE     = '{valid: 1'b0, rd: 3'd0, reg_write: 1'b0, load: 1'b0};

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    state_t                 state_q, state_d;
    logic [2:0]             flush_cnt_q, flush_cnt_d;
    trk_t                   ex_q, ex_d;
    trk_t                   mem_q, mem_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    logic load_use_s;
    logic issue_s;
    logic hold_s;
    logic clear_s;

    // A load in EX cannot feed EX next cycle; only the MEM-stage copy is usable.
    function automatic logic [1:0] fwd_sel(input logic [2:0] opnd, input trk_t ex, input trk_t mem);
        logic [1:0] sel;
        if (ex.valid && ex.reg_write && !ex.load && (ex.rd == opnd)) begin
            sel = SEL_EX;
        end else if (mem.valid && mem.reg_write && (mem.rd == opnd)) begin
            sel = SEL_MEM;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Hazard detection, sequencing FSM next state, tracking and counter updates.
    always_comb begin
        load_use_s    = id_valid & ex_q.valid & ex_q.reg_write & ex_q.load &
                        ((ex_q.rd == id_rs) | (ex_q.rd == id_rd));
        hold_s        = 1'b0;
        clear_s       = 1'b0;
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    clear_s     = 1'b1;
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_RELOAD;
                end else if (load_use_s) begin
                    hold_s  = 1'b1;
                    clear_s = 1'b1;
                end else begin
                    clear_s = 1'b0;
                end
            end
            ST_FLUSH: begin
                clear_s = 1'b1;
                if (branch_taken) begin
                    flush_cnt_d = FLUSH_RELOAD;
                end else if (flush_cnt_q == 3'd0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: begin
                clear_s     = 1'b1;
                state_d     = ST_RUN;
                flush_cnt_d = 3'd0;
            end
        endcase

        issue_s = id_valid & ~load_use_s & (state_q == ST_RUN) & ~branch_taken;

        if (issue_s) begin
            ex_d = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, load: id_load};
        end else begin
            ex_d = TRK_NONE;
        end
        mem_d = ex_q;

        if (hold_s && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State, tracking entries and stall counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= 3'd0;
            ex_q          <= TRK_NONE;
            mem_q         <= TRK_NONE;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ifid_hold   = hold_s;
    assign idex_enable = 1'b1;
    assign idex_clear  = clear_s;
    assign fwd_rs_sel  = fwd_sel(id_rs, ex_q, mem_q);
    assign fwd_rd_sel  = fwd_sel(id_rd, ex_q, mem_q);
    assign stall_count = stall_count_q;

endmodule
